// File: rtl/gpio_intr_ctrl.sv
// Per-pin GPIO edge/level interrupt detector with sticky pending bits.
// Define GPIO_INTR_LEVEL_EN to add high/low level detection ports.
module gpio_intr_ctrl #(
  parameter int WD = 32
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic [WD-1:0] gpio_in,
  input  logic [WD-1:0] cfg_rise_en,
  input  logic [WD-1:0] cfg_fall_en,
`ifdef GPIO_INTR_LEVEL_EN
  input  logic [WD-1:0] cfg_lvl_hi_en,
  input  logic [WD-1:0] cfg_lvl_lo_en,
`endif
  input  logic [WD-1:0] cfg_intr_mask,
  input  logic [WD-1:0] reg_clr,
  input  logic [WD-1:0] reg_set,
  output logic [WD-1:0] intr_stat,
  output logic          intr_req
);

  logic          r_arm;
  logic [WD-1:0] r_gpio_d;
  logic [WD-1:0] r_stat;
  logic          r_req;

  logic [WD-1:0] w_arm;
  logic [WD-1:0] w_rise;
  logic [WD-1:0] w_fall;
  logic [WD-1:0] w_lvl;
  logic [WD-1:0] w_evt;

  // Detection is held off until gpio_d holds a real sample.
  assign w_arm  = {WD{r_arm}};
  assign w_rise = cfg_rise_en & gpio_in & ~r_gpio_d;
  assign w_fall = cfg_fall_en & ~gpio_in & r_gpio_d;

`ifdef GPIO_INTR_LEVEL_EN
  assign w_lvl = (cfg_lvl_hi_en & gpio_in)
               | (cfg_lvl_lo_en & ~gpio_in);
`else
  assign w_lvl = '0;
`endif

  assign w_evt = w_arm & (w_rise | w_fall | w_lvl);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm    <= 1'b0;
      r_gpio_d <= '0;
      r_stat   <= '0;
      r_req    <= 1'b0;
    end else begin
      r_arm    <= 1'b1;
      r_gpio_d <= gpio_in;
      r_stat   <= w_evt | reg_set
                | (r_stat & ~reg_clr);
      r_req    <= |(r_stat & cfg_intr_mask);
    end
  end

  assign intr_stat = r_stat;
  assign intr_req  = r_req;

endmodule

// File: tb/tb_gpio_intr_ctrl.sv
// Scoreboard bench for gpio_intr_ctrl, WD = 4.
// Level-detect cases run only when GPIO_INTR_LEVEL_EN is defined.
module tb_gpio_intr_ctrl;

  localparam int WD = 4;

  logic          mclk    = 1'b0;
  logic          reset_n = 1'b0;
  logic [WD-1:0] gpio_in = '0;
  logic [WD-1:0] rise    = '0;
  logic [WD-1:0] fall    = '0;
  logic [WD-1:0] hi      = '0;
  logic [WD-1:0] lo      = '0;
  logic [WD-1:0] mask    = '0;
  logic [WD-1:0] clr     = '0;
  logic [WD-1:0] set     = '0;
  logic [WD-1:0] stat;
  logic          req;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [WD-1:0] stat;
    logic          req;
  } exp_t;

  exp_t q[$];

  logic          m_arm  = 1'b0;
  logic [WD-1:0] m_d    = '0;
  logic [WD-1:0] m_stat = '0;
  logic          m_req  = 1'b0;

  always #5 mclk = ~mclk;

  gpio_intr_ctrl #(.WD(WD)) u_dut (
    .mclk          (mclk),
    .reset_n       (reset_n),
    .gpio_in       (gpio_in),
    .cfg_rise_en   (rise),
    .cfg_fall_en   (fall),
`ifdef GPIO_INTR_LEVEL_EN
    .cfg_lvl_hi_en (hi),
    .cfg_lvl_lo_en (lo),
`endif
    .cfg_intr_mask (mask),
    .reg_clr       (clr),
    .reg_set       (set),
    .intr_stat     (stat),
    .intr_req      (req)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_arm  = 1'b0;
    m_d    = '0;
    m_stat = '0;
    m_req  = 1'b0;
  endtask

  // Predict the next edge, push, clock, then pop and compare.
  task automatic tick();
    exp_t          e;
    logic [WD-1:0] ev;
    logic [WD-1:0] lv;
    logic          nreq;
    lv = '0;
`ifdef GPIO_INTR_LEVEL_EN
    lv = (hi & gpio_in) | (lo & ~gpio_in);
`endif
    ev = '0;
    if (m_arm)
      ev = (rise & gpio_in & ~m_d)
         | (fall & ~gpio_in & m_d) | lv;
    nreq   = |(m_stat & mask);
    m_stat = ev | set | (m_stat & ~clr);
    m_req  = nreq;
    m_d    = gpio_in;
    m_arm  = 1'b1;
    e.stat = m_stat;
    e.req  = m_req;
    q.push_back(e);
    @(posedge mclk);
    #1;
    e = q.pop_front();
    check("sb_stat", stat, e.stat);
    check("sb_req", req, e.req);
    @(negedge mclk);
  endtask

  initial begin
    gpio_in = 4'hF;
    rise    = 4'hF;
    @(negedge mclk);
    check("rst_stat", stat, 0);
    check("rst_req", req, 0);
    reset_n = 1'b1;

    // Pins high at reset release must not look like rises.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("arm_sup", stat, 0);
    end

    // Rise on pin 0, then an unenabled fall.
    rise    = 4'h1;
    mask    = 4'h1;
    gpio_in = 4'h0;
    tick();
    gpio_in = 4'h1;
    tick();
    check("rise_stat", stat, 4'h1);
    check("rise_req0", req, 0);
    tick();
    check("rise_req1", req, 1);
    gpio_in = 4'h0;
    tick();
    check("nofall", stat, 4'h1);
    clr = 4'h1;
    tick();
    clr = 4'h0;
    check("clr0", stat, 0);
    tick();
    check("clr0_req", req, 0);

    // Set wins over a simultaneous clear.
    rise    = 4'h4;
    mask    = 4'h4;
    gpio_in = 4'h4;
    tick();
    gpio_in = 4'h0;
    tick();
    gpio_in = 4'h4;
    clr     = 4'h4;
    tick();
    check("set_wins", stat, 4'h4);
    tick();
    clr = 4'h0;
    check("clr2", stat, 0);
    check("clr2_req1", req, 1);
    tick();
    check("clr2_req0", req, 0);

    // Masked fall on pin 3, then unmask.
    mask    = 4'h0;
    rise    = 4'h0;
    fall    = 4'h8;
    gpio_in = 4'hC;
    tick();
    check("no_rise3", stat, 0);
    gpio_in = 4'h4;
    tick();
    check("fall3", stat, 4'h8);
    tick();
    check("masked", req, 0);
    mask = 4'h8;
    tick();
    check("unmask", req, 1);
    clr = 4'h8;
    tick();
    clr = 4'h0;
    tick();
    check("fall3_clr", req, 0);
    fall = 4'h0;

`ifdef GPIO_INTR_LEVEL_EN
    hi      = 4'h2;
    gpio_in = 4'h2;
    tick();
    check("lvl_set", stat, 4'h2);
    clr = 4'h2;
    tick();
    clr = 4'h0;
    check("lvl_hold", stat, 4'h2);
    gpio_in = 4'h0;
    tick();
    clr = 4'h2;
    tick();
    clr = 4'h0;
    check("lvl_clr", stat, 0);
    hi = 4'h0;
`endif

    // Scoreboard-only random traffic.
    for (int i = 0; i < 60; i++) begin
      gpio_in = WD'($urandom);
      rise    = WD'($urandom);
      fall    = WD'($urandom);
      mask    = WD'($urandom);
`ifdef GPIO_INTR_LEVEL_EN
      hi = WD'($urandom) & WD'($urandom);
      lo = WD'($urandom) & WD'($urandom);
`endif
      clr = ($urandom_range(0, 3) == 0) ? WD'($urandom) : '0;
      set = ($urandom_range(0, 5) == 0) ? WD'($urandom) : '0;
      tick();
    end
    clr  = '0;
    set  = '0;
    hi   = '0;
    lo   = '0;
    rise = '0;
    fall = '0;

    // Software set with all enables off.
    set = 4'hF;
    tick();
    set  = 4'h0;
    mask = 4'hF;
    check("sw_set", stat, 4'hF);
    tick();
    tick();
    check("pre_rst_req", req, 1);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_stat", stat, 0);
    check("arst_req", req, 0);
    model_reset();
    @(negedge mclk);
    rise    = 4'hF;
    gpio_in = 4'hF;
    reset_n = 1'b1;
    tick();
    tick();
    check("rearm_sup", stat, 0);
    gpio_in = 4'h0;
    tick();
    gpio_in = 4'h5;
    tick();
    check("rearm_rise", stat, 4'h5);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
